instr_fetch_stage: RTL and testbench
====================================

// Module: instr_fetch_stage
// PURPOSE
//  IF stage of the 5-stage RV32I pipeline. Owns the PC register and drives the word address of the
//  combinational instruction ROM. Captures the returned word into the IF/ID pipeline register.
//  Supports a hold for load-use stalls and a redirect from EX for taken branches, jal and jalr.
//  Counts instructions delivered to ID for debug.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded by reset
//  ADDR_W     6              ROM word-address width; rom_addr = pc[ADDR_W+1:2]
//  NOP_INSTR  32'h0000_0000  bubble word written to id_instr on flush/reset (ROM nop encoding)
// PORTS
//  clk              in   1       rising-edge clock
//  rst              in   1       synchronous, active-high reset
//  stall            in   1       hazard unit: hold PC and IF/ID this cycle
//  redirect         in   1       EX: branch/jump taken this cycle
//  redirect_target  in   32      EX: next PC when redirect=1
//  rom_addr         out  ADDR_W  word address to instruction ROM (combinational from pc)
//  rom_data         in   32      instruction word from ROM, valid same cycle as rom_addr
//  if_pc            out  32      current fetch PC (pc register)
//  id_pc            out  32      PC of instruction in IF/ID
//  id_pc_plus4      out  32      id_pc + 4 (link value for jal/jalr)
//  id_instr         out  32      instruction in IF/ID
//  id_valid         out  1       IF/ID holds a real instruction (0 = bubble)
//  fetch_count      out  32      number of valid instructions loaded into IF/ID since reset
// BEHAVIOUR
//  - One clock, clk. Reset is synchronous and active-high (rst). All state updates on posedge clk.
//  - Reset values:
//      pc = RESET_PC, id_pc = 0, id_pc_plus4 = 0, id_instr = NOP_INSTR, id_valid = 0, fetch_count = 0.
//  - rom_addr = pc[ADDR_W+1:2], combinational. Upper PC bits alias; no range fault.
//  - Per-edge priority: rst > redirect > stall > advance.
//      rst:      load reset values; redirect/stall ignored.
//      redirect: pc <= {redirect_target[31:2],2'b00} (low bits forced 0).
//                IF/ID flushed: id_instr = NOP_INSTR, id_valid = 0, id_pc = id_pc_plus4 = 0.
//                Overrides stall; the ID instruction is younger than the EX branch.
//      stall:    pc and every id_* output hold their value; fetch_count holds.
//      advance:  id_pc <= pc; id_pc_plus4 <= pc + 4; id_instr <= rom_data; id_valid <= 1;
//                pc <= pc + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0); fetch_count += 1.
//  - Latency: a word fetched at PC p appears on id_instr 1 cycle after p is on if_pc, absent stall.
//    After a redirect there is one bubble cycle, then the target word.
//  - fetch_count increments only on advance edges, wraps at 2^32, never on a redirect or stall edge.
//  - Stall held N cycles leaves IF/ID unchanged for N cycles. The same word is re-presented
//    afterwards; no word is skipped or duplicated.
//  - Reset asserted mid-stream: next edge gives pc = RESET_PC and a bubble in ID.
//    The first post-reset advance loads the RESET_PC word.
//  - No internal FSM beyond the registers above; the design is purely synchronous with no latches.
// TESTING
//  1 rst 2 cyc, release, free-run with program ROM
//    -> id_instr 0x00003f37 (id_pc 0), then 0x02000fe7 (id_pc 4), id_valid=1;
//       fetch_count=2 after 2 advances.
//  2 redirect=1, target 0x20, while if_pc=0x8
//    -> next edge if_pc=0x20, id_valid=0, id_instr=0;
//       following edge id_instr=0x00001c63, id_pc=0x20, id_pc_plus4=0x24.
//  3 stall=1 for 3 cycles with id_pc=0xC (0x00432e83)
//    -> id_*, if_pc, fetch_count frozen 3 cycles;
//       release -> id_pc=0x10, id_instr=0x002e9293.
//  4 stall=1 and redirect=1 same edge, target 0x08
//    -> redirect wins: if_pc=0x08, id_valid=0, fetch_count unchanged.
//  5 redirect target 0x22 -> if_pc=0x20. Force pc 0xFFFFFFFC via redirect, advance
//    -> if_pc=0, rom_addr=0.
//  6 rst asserted for 1 cycle mid-run with fetch_count=9
//    -> if_pc=0, id_valid=0, fetch_count=0; next edge id_instr=0x00003f37.

Source files
------------

// File: rtl/instr_fetch_stage.sv
// ---------------------------------------------------------------------------
// instr_fetch_stage
//
// IF stage of the 5-stage RV32I pipeline. Owns the PC register, drives the
// word address of the combinational instruction ROM, and captures the
// returned word into the IF/ID pipeline register. Supports a hazard-unit
// hold (stall) and an EX redirect for taken branches, jal and jalr. A debug
// counter tracks how many real instructions have been handed to ID.
//
// Parameters
//   RESET_PC   PC value loaded by reset
//   ADDR_W     ROM word-address width; rom_addr = pc[ADDR_W+1:2]
//   NOP_INSTR  bubble word placed in id_instr on flush/reset
//
// Ports
//   clk              rising-edge clock
//   rst              synchronous, active-high reset
//   stall            hold PC and IF/ID this cycle
//   redirect         branch/jump taken in EX this cycle
//   redirect_target  next PC when redirect=1 (low two bits ignored)
//   rom_addr         word address to instruction ROM (combinational from pc)
//   rom_data         instruction word from ROM, valid same cycle as rom_addr
//   if_pc            current fetch PC
//   id_pc            PC of instruction in IF/ID
//   id_pc_plus4      id_pc + 4 (link value for jal/jalr)
//   id_instr         instruction in IF/ID
//   id_valid         IF/ID holds a real instruction (0 = bubble)
//   fetch_count      valid instructions loaded into IF/ID since reset
// ---------------------------------------------------------------------------
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ADDR_W    = 6,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_target,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic [31:0]       if_pc,
  output logic [31:0]       id_pc,
  output logic [31:0]       id_pc_plus4,
  output logic [31:0]       id_instr,
  output logic              id_valid,
  output logic [31:0]       fetch_count
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] target_aligned;

  // Sequential PC increment; wraps naturally at 2^32.
  assign pc_plus4 = pc + 32'd4;

  // Redirect targets are forced word-aligned; masking keeps every target
  // bit in the expression so nothing is left dangling.
  assign target_aligned = redirect_target & ~32'd3;

  // Upper PC bits alias onto the ROM; there is no range fault.
  assign rom_addr = pc[ADDR_W+1:2];
  assign if_pc    = pc;

  // Priority: rst > redirect > stall > advance.
  // A redirect overrides stall because the instruction sitting in ID is
  // younger than the branch in EX and must be squashed anyway.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      id_pc       <= '0;
      id_pc_plus4 <= '0;
      id_instr    <= NOP_INSTR;
      id_valid    <= 1'b0;
      fetch_count <= '0;
    end else if (redirect) begin
      pc          <= target_aligned;
      id_pc       <= '0;
      id_pc_plus4 <= '0;
      id_instr    <= NOP_INSTR;
      id_valid    <= 1'b0;
    end else if (!stall) begin
      pc          <= pc_plus4;
      id_pc       <= pc;
      id_pc_plus4 <= pc_plus4;
      id_instr    <= rom_data;
      id_valid    <= 1'b1;
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
module tb_instr_fetch_stage;

  localparam int unsigned ADDR_W = 6;

  logic              clk;
  logic              rst;
  logic              stall;
  logic              redirect;
  logic [31:0]       redirect_target;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_data;
  logic [31:0]       if_pc;
  logic [31:0]       id_pc;
  logic [31:0]       id_pc_plus4;
  logic [31:0]       id_instr;
  logic              id_valid;
  logic [31:0]       fetch_count;

  logic [31:0] rom [64];

  int unsigned n_checks;
  int unsigned n_fail;

  instr_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .ADDR_W   (ADDR_W),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .if_pc          (if_pc),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .id_instr       (id_instr),
    .id_valid       (id_valid),
    .fetch_count    (fetch_count)
  );

  assign rom_data = rom[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the directed sequence is short; anything beyond this is a hang.
  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_id(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                          input logic e_valid, input logic [31:0] e_if_pc, input logic [31:0] e_fc);
    check_eq({tag, ".id_pc"},       id_pc,       e_pc);
    check_eq({tag, ".id_pc_plus4"}, id_pc_plus4, e_valid ? e_pc + 32'd4 : 32'd0);
    check_eq({tag, ".id_instr"},    id_instr,    e_instr);
    check_eq({tag, ".id_valid"},    {31'd0, id_valid}, {31'd0, e_valid});
    check_eq({tag, ".if_pc"},       if_pc,       e_if_pc);
    check_eq({tag, ".fetch_count"}, fetch_count, e_fc);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 64; i++) rom[i] = 32'h1000_0000 | 32'(i);
    rom[0]  = 32'h0000_3f37;
    rom[1]  = 32'h0200_0fe7;
    rom[3]  = 32'h0043_2e83;
    rom[4]  = 32'h002e_9293;
    rom[8]  = 32'h0000_1c63;

    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = '0;

    // 1: reset for two cycles, then free-run
    step(); step();
    check_id("reset", 32'h0, 32'h0, 1'b0, 32'h0, 32'd0);
    check_eq("reset.rom_addr", {26'd0, rom_addr}, 32'd0);
    rst = 1'b0;
    step();
    check_id("run0", 32'h0, 32'h0000_3f37, 1'b1, 32'h4, 32'd1);
    step();
    check_id("run1", 32'h4, 32'h0200_0fe7, 1'b1, 32'h8, 32'd2);

    // 2: redirect to 0x20 while if_pc = 0x8
    redirect = 1'b1; redirect_target = 32'h20;
    step();
    check_id("redir_bubble", 32'h0, 32'h0, 1'b0, 32'h20, 32'd2);
    redirect = 1'b0;
    step();
    check_id("redir_target", 32'h20, 32'h0000_1c63, 1'b1, 32'h24, 32'd3);

    // 3: bring 0xC into ID, then stall three cycles
    redirect = 1'b1; redirect_target = 32'hC;
    step();
    redirect = 1'b0;
    step();
    check_id("pre_stall", 32'hC, 32'h0043_2e83, 1'b1, 32'h10, 32'd4);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_id("stall", 32'hC, 32'h0043_2e83, 1'b1, 32'h10, 32'd4);
    end
    stall = 1'b0;
    step();
    check_id("post_stall", 32'h10, 32'h002e_9293, 1'b1, 32'h14, 32'd5);

    // 4: stall and redirect on the same edge: redirect wins
    stall = 1'b1; redirect = 1'b1; redirect_target = 32'h8;
    step();
    check_id("stall_redir", 32'h0, 32'h0, 1'b0, 32'h8, 32'd5);
    stall = 1'b0; redirect = 1'b0;
    step();
    check_id("stall_redir_next", 32'h8, 32'h1000_0002, 1'b1, 32'hC, 32'd6);

    // 5: unaligned target is aligned; PC wrap at 2^32
    redirect = 1'b1; redirect_target = 32'h22;
    step();
    check_eq("align.if_pc", if_pc, 32'h20);
    check_eq("align.rom_addr", {26'd0, rom_addr}, 32'd8);
    redirect_target = 32'hFFFF_FFFC;
    step();
    check_eq("top.if_pc", if_pc, 32'hFFFF_FFFC);
    check_eq("top.rom_addr", {26'd0, rom_addr}, 32'd63);
    redirect = 1'b0;
    step();
    check_eq("wrap.if_pc", if_pc, 32'h0);
    check_eq("wrap.rom_addr", {26'd0, rom_addr}, 32'd0);
    check_eq("wrap.id_pc", id_pc, 32'hFFFF_FFFC);
    check_eq("wrap.id_pc_plus4", id_pc_plus4, 32'h0);
    check_eq("wrap.id_instr", id_instr, 32'h1000_003F);
    check_eq("wrap.fetch_count", fetch_count, 32'd7);

    // 6: mid-run reset with fetch_count = 9
    step(); step();
    check_id("pre_rst", 32'h4, 32'h0200_0fe7, 1'b1, 32'h8, 32'd9);
    rst = 1'b1;
    step();
    check_id("mid_rst", 32'h0, 32'h0, 1'b0, 32'h0, 32'd0);
    rst = 1'b0;
    step();
    check_id("after_rst", 32'h0, 32'h0000_3f37, 1'b1, 32'h4, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
